// File: rtl/dm_cache_pkg.sv
// Shared geometry and FSM state encoding so dm_cache and its backing-store
// responder agree on line size, offset width and transaction phases.
package dm_cache_pkg;

  localparam int CL_ADDR_W      = 32;
  localparam int CL_DATA_W      = 32;
  localparam int CL_LINE_WORDS  = 4;
  localparam int CL_OFFSET_W    = $clog2(CL_LINE_WORDS) + 2;
  localparam int CL_MEM_LATENCY = 3;
  localparam int CL_MEM_DEPTH   = 1024;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER,
    DONE
  } mem_state_t;

endpackage

// File: rtl/dm_cache_mem_if.sv
// Line refill / write-back bus between the cache miss handler (master)
// and the backing-store responder (slave).
interface dm_cache_mem_if
  import dm_cache_pkg::*;
#(
  parameter int ADDR_W = CL_ADDR_W,
  parameter int DATA_W = CL_DATA_W
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_busy;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_wready;
  logic              mem_done;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_busy, mem_rvalid, mem_rdata, mem_wready, mem_done
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_busy, mem_rvalid, mem_rdata, mem_wready, mem_done
  );

endinterface

// File: rtl/dm_cache_mem_array.sv
// Single-port word store: synchronous write, registered read, no reset so
// it maps onto block RAM.
module dm_cache_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    rdata <= r_mem[addr];
  end

endmodule

// File: rtl/dm_cache_mem.sv
// Backing-store responder for the cache miss port: after a fixed latency it
// streams a whole line out of, or into, the word array one beat per cycle.
module dm_cache_mem
  import dm_cache_pkg::*;
#(
  parameter int ADDR_W     = CL_ADDR_W,
  parameter int DATA_W     = CL_DATA_W,
  parameter int LINE_WORDS = CL_LINE_WORDS,
  parameter int LATENCY    = CL_MEM_LATENCY,
  parameter int DEPTH      = CL_MEM_DEPTH
) (
  input logic           clk,
  input logic           rst_n,
  dm_cache_mem_if.slave bus
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int LINE_W = IDX_W - BEAT_W;
  localparam int LAT_W  = $clog2(LATENCY + 1);

  mem_state_t        r_state;
  mem_state_t        w_nextState;
  logic [LAT_W-1:0]  r_latCnt;
  logic [BEAT_W-1:0] r_beat;
  logic [LINE_W-1:0] r_lineIdx;
  logic              r_we;
  logic [DATA_W-1:0] r_rdata;

  logic              w_lastBeat;
  logic              w_xferRead;
  logic [BEAT_W-1:0] w_arrayBeat;
  logic [IDX_W-1:0]  w_arrayAddr;
  logic              w_arrayWe;
  logic [DATA_W-1:0] w_arrayRdata;
  logic              w_unusedAddr;

  assign w_lastBeat   = (r_beat == BEAT_W'(LINE_WORDS - 1));
  assign w_xferRead   = (r_state == XFER) && !r_we;
  assign w_unusedAddr = ^bus.mem_addr[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (bus.mem_req)           w_nextState = WAIT;
      WAIT: if (r_latCnt == '0)        w_nextState = XFER;
      XFER: if (w_lastBeat)            w_nextState = DONE;
      DONE:                            w_nextState = IDLE;
      default:                         w_nextState = IDLE;
    endcase
  end

  // The line index is kept apart from the beat count so beat arithmetic
  // wraps inside the line instead of carrying into the base.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_latCnt  <= '0;
      r_beat    <= '0;
      r_lineIdx <= '0;
      r_we      <= 1'b0;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.mem_req) begin
            r_lineIdx <= bus.mem_addr[IDX_W+1 -: LINE_W];
            r_we      <= bus.mem_we;
            r_latCnt  <= LAT_W'(LATENCY - 1);
            r_beat    <= '0;
          end
        end
        WAIT: begin
          if (r_latCnt != '0) begin
            r_latCnt <= r_latCnt - LAT_W'(1);
          end else begin
            r_beat <= '0;
          end
        end
        XFER: begin
          r_beat <= r_beat + BEAT_W'(1);
          if (!r_we) begin
            r_rdata <= w_arrayRdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Reads run one word ahead of the visible beat to hide the array's
  // registered read; writes address the current beat directly.
  always_comb begin
    w_arrayBeat = '0;
    if (r_state == XFER) begin
      w_arrayBeat = r_we ? r_beat : r_beat + BEAT_W'(1);
    end
    w_arrayAddr = {r_lineIdx, w_arrayBeat};
    w_arrayWe   = (r_state == XFER) && r_we;
  end

  always_comb begin
    bus.mem_busy   = (r_state != IDLE);
    bus.mem_rvalid = w_xferRead;
    bus.mem_wready = (r_state == XFER) && r_we;
    bus.mem_done   = (r_state == DONE);
    bus.mem_rdata  = w_xferRead ? w_arrayRdata : r_rdata;
  end

  dm_cache_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (w_arrayWe),
    .addr  (w_arrayAddr),
    .wdata (bus.mem_wdata),
    .rdata (w_arrayRdata)
  );

endmodule
